spi_master_mode0_tx: RTL and testbench

SPI_MASTER_MODE0_TX -- requirements
Module: spi_master_mode0_tx

---
 rtl/spi_pkg.sv | 42 ++++
 rtl/spi_half_tick.sv | 56 +++++
 rtl/spi_master_mode0_tx.sv | 209 ++++++++++++++++++++
 tb/tb_spi_master_mode0_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//
// Purpose : Shared definitions for the mode-0 SPI transmit master.
//           - spi_state_t     : the master's FSM state encoding
//           - SPI_DATA_W      : default frame length in bits
//           - SPI_CLK_DIV_DEF : default clk cycles per SCLK half-period
//           - spi_is_timed()  : true for the states whose length is set by
//                               the half-period tick
// Ports   : none (package)
// -----------------------------------------------------------------------------
package spi_pkg;

  // Default frame length in bits.
  localparam int SPI_DATA_W = 16;

  // Default number of clk cycles per SCLK half-period.
  localparam int SPI_CLK_DIV_DEF = 2;

  // Width of the half-period counter; covers the full 1..255 divider range.
  localparam int SPI_DIV_CNT_W = 8;

  // FSM states of the master.
  //   ST_IDLE  : waiting for start, CS_n high, SCLK low
  //   ST_SETUP : CS_n low, first bit on MOSI, SCLK low for one half-period
  //   ST_HIGH  : SCLK high half-period (MISO sampled on entry)
  //   ST_LOW   : SCLK low half-period (MOSI advanced on entry)
  //   ST_DONE  : one-cycle frame end, done pulse, rx_data updated
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  // States whose duration is measured in SCLK half-periods.
  function automatic logic spi_is_timed(input spi_state_t s);
    return (s == ST_SETUP) || (s == ST_HIGH) || (s == ST_LOW);
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// -----------------------------------------------------------------------------
// spi_half_tick
//
// Purpose : Half-period timer for the SPI master. While en is high it emits a
//           one-cycle tick every CLK_DIV clk cycles. The counter restarts from
//           zero whenever en is low and after every tick; the master changes
//           state only on a tick (or while en is low), so the count restarts
//           on each state change and every timed state lasts exactly CLK_DIV
//           cycles.
//
// Parameters:
//   CLK_DIV : clk cycles per tick, 1..255
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous reset, active-high
//   en   in   count enable (high while the master is in a timed state)
//   tick out  one-cycle pulse on the last cycle of each half-period
// -----------------------------------------------------------------------------
module spi_half_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // Terminal count: the tick is raised on the CLK_DIV-th cycle of a phase.
  localparam logic [SPI_DIV_CNT_W-1:0] DIV_LAST = SPI_DIV_CNT_W'(CLK_DIV - 1);

  logic [SPI_DIV_CNT_W-1:0] cnt_reg;
  logic [SPI_DIV_CNT_W-1:0] cnt_next;

  // Combinational tick from the registered count, so the FSM can act on the
  // same edge that ends the half-period. With CLK_DIV=1 the tick is simply en.
  assign tick = en && (cnt_reg == DIV_LAST);

  always_comb begin
    cnt_next = cnt_reg + SPI_DIV_CNT_W'(1);
    if (!en || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/spi_master_mode0_tx.sv
// -----------------------------------------------------------------------------
// spi_master_mode0_tx
//
// Purpose : SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. A start pulse in
//           IDLE latches tx_data and runs one frame of DATA_W bits:
//             SETUP (CLK_DIV cycles, SCLK low, first bit on MOSI)
//             HIGH/LOW pairs (CLK_DIV cycles each) x DATA_W
//             DONE (1 cycle, done pulse)
//           MISO is sampled on each SCLK rising edge, MOSI changes on each
//           falling edge. busy covers SETUP through DONE:
//           (2*DATA_W+1)*CLK_DIV+1 cycles. With start held high, frames run
//           back to back with CS_n high for DONE plus one IDLE cycle.
//
// Configuration macro:
//   SPI_MISO_RX_EN : when defined, MISO is shifted into an rx register and
//                    presented on rx_data in the DONE cycle. When undefined,
//                    there is no receive path, MISO is ignored and rx_data is
//                    constant 0. Transmit timing is the same in both builds.
//
// Parameters:
//   CLK_DIV : clk cycles per SCLK half-period, 1..255
//   DATA_W  : frame length in bits (>= 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   start    in   frame request, sampled only in IDLE
//   tx_data  in   frame to send, MSB first (latched at acceptance)
//   MISO     in   serial data from the slave
//   SCLK     out  serial clock, idles low
//   MOSI     out  serial data to the slave, 0 when idle
//   CS_n     out  chip select, active-low
//   busy     out  high from frame acceptance through the DONE cycle
//   done     out  one-cycle pulse at frame end
//   rx_data  out  last frame captured from MISO
// -----------------------------------------------------------------------------
module spi_master_mode0_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  // Bit counter must be able to hold DATA_W itself (value after last LOW).
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  spi_state_t        state_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              sclk_reg;
  logic              cs_n_reg;
  logic              busy_reg;
  logic              done_reg;

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_data_reg;
`endif

  // Half-period tick, enabled only in the timed states.
  logic half_en;
  logic half_tick;

  assign half_en = spi_is_timed(state_reg);

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (half_en),
    .tick (half_tick)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  //
  // MOSI is the MSB of the tx shift register. The register is loaded at
  // acceptance and shifted left with zero fill once per bit, so after the
  // last bit it is all zeros again; this is what keeps MOSI low in DONE and
  // IDLE without any extra output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef SPI_MISO_RX_EN
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; only the LOW->DONE transition sets it.
      done_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          sclk_reg <= 1'b0;
          cs_n_reg <= 1'b1;
          busy_reg <= 1'b0;
          if (start) begin
            state_reg    <= ST_SETUP;
            tx_shift_reg <= tx_data;
            bit_cnt_reg  <= '0;
            cs_n_reg     <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (half_tick) begin
            // First rising edge: sample MISO as SCLK goes high.
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
`ifdef SPI_MISO_RX_EN
            rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], MISO};
`endif
          end
        end

        ST_HIGH: begin
          if (half_tick) begin
            // Falling edge: advance MOSI to the next bit.
            state_reg    <= ST_LOW;
            sclk_reg     <= 1'b0;
            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (half_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
              // All bits clocked out: release CS_n and report the frame.
              state_reg <= ST_DONE;
              cs_n_reg  <= 1'b1;
              done_reg  <= 1'b1;
`ifdef SPI_MISO_RX_EN
              rx_data_reg <= rx_shift_reg;
`endif
            end else begin
              // Next rising edge: sample MISO as SCLK goes high.
              state_reg <= ST_HIGH;
              sclk_reg  <= 1'b1;
`ifdef SPI_MISO_RX_EN
              rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], MISO};
`endif
            end
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here; a held start is picked
          // up in the following IDLE cycle.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          sclk_reg  <= 1'b0;
          cs_n_reg  <= 1'b1;
        end

        default: begin
          state_reg <= ST_IDLE;
          sclk_reg  <= 1'b0;
          cs_n_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all come straight from registers)
  // ---------------------------------------------------------------------------
  assign SCLK = sclk_reg;
  assign MOSI = tx_shift_reg[DATA_W-1];
  assign CS_n = cs_n_reg;
  assign busy = busy_reg;
  assign done = done_reg;

`ifdef SPI_MISO_RX_EN
  assign rx_data = rx_data_reg;
`else
  // No receive path in this build: MISO is intentionally left unconnected.
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_mode0_tx.sv
`timescale 1ns/1ps
module tb_spi_master_mode0_tx;
  import spi_pkg::*;

  localparam int DW = SPI_DATA_W;
  localparam int CD = SPI_CLK_DIV_DEF;
  localparam int BUSY_CYC = (2*DW+1)*CD+1;
`ifdef SPI_MISO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          miso;
  logic          sclk, mosi, cs_n, busy, done;
  logic [DW-1:0] rx_data;

  // With the receive path built, MISO is looped back so every frame has a
  // known rx value; otherwise MISO toggles freely (except in the loopback test).
  logic loop_en = RX_EN;
  logic tog = 1'b0;
  assign miso = loop_en ? mosi : tog;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  spi_master_mode0_tx #(
    .CLK_DIV (CD),
    .DATA_W  (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .MISO    (miso),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .CS_n    (cs_n),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling clk edge, rebuilds each frame from MOSI at
  // SCLK rising edges and compares against the scoreboard on the done pulse.
  // ---------------------------------------------------------------------------
  logic          prev_sclk = 1'b0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] mosi_word = '0;
  int rises = 0, busy_cnt = 0, frames_done = 0;
  int gap_cnt = 0, last_gap = 0, sclk_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_sclk = 1'b0;
      prev_done = 1'b0;
      mosi_word = '0;
      rises     = 0;
      busy_cnt  = 0;
      gap_cnt   = 0;
    end else begin
      if (cs_n && sclk) sclk_viol++;
      if (sclk && !prev_sclk && !cs_n) begin
        mosi_word = {mosi_word[DW-2:0], mosi};
        rises++;
      end
      if (busy) busy_cnt++;
      if (prev_done) check_eq("done_width", {31'd0, done}, 32'd0);
      if (cs_n) begin
        gap_cnt++;
      end else if (gap_cnt != 0) begin
        last_gap = gap_cnt;
        gap_cnt  = 0;
      end
      if (done) begin
        gap_cnt = 1;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("mosi_word", {16'd0, mosi_word}, {16'd0, mon_e.tx});
          check_eq("rise_count", rises, DW);
          check_eq("busy_cycles", busy_cnt, BUSY_CYC);
          check_eq("rx_data", {16'd0, rx_data}, {16'd0, mon_e.rx});
          check_eq("done_cs_n", {31'd0, cs_n}, 32'd1);
          check_eq("done_sclk", {31'd0, sclk}, 32'd0);
          $display("frame %0d: tx=%h mosi=%h rx=%h rises=%0d busy=%0d",
                   frames_done, mon_e.tx, mosi_word, rx_data, rises, busy_cnt);
        end
        frames_done++;
        mosi_word = '0;
        rises     = 0;
        busy_cnt  = 0;
      end
      prev_sclk = sclk;
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [DW-1:0] v);
    @(posedge clk); #1;
    tx_data = v;
    start   = 1'b1;
    exp_q.push_back('{tx: v, rx: (RX_EN ? v : {DW{1'b0}})});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frames_done < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, frames_done, target);
  endtask

  initial begin
    int n;

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("rst_sclk", {31'd0, sclk}, 32'd0);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rx", {16'd0, rx_data}, 32'd0);
    rst = 1'b0;

    // Single frame.
    send(16'hA5C3);
    wait_frames(1, "t1_timeout");
    @(posedge clk); #1;
    check_eq("t1_idle_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("t1_idle_mosi", {31'd0, mosi}, 32'd0);

    // Loopback frame.
    loop_en = 1'b1;
    send(16'h3C5A);
    wait_frames(2, "t2_timeout");
    loop_en = RX_EN;

    // Start and tx_data change mid-frame must be ignored.
    send(16'hA5C3);
    repeat (20) @(posedge clk);
    #1;
    tx_data = 16'hFFFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frames(3, "t3_timeout");
    repeat (100) @(posedge clk);
    #1;
    check_eq("t3_no_extra", frames_done, 3);
    check_eq("t3_busy_idle", {31'd0, busy}, 32'd0);

    // Reset after the 5th rising SCLK edge.
    send(16'hA5C3);
    n = 0;
    while (rises < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("t4_reach_5", rises, 5);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("t4_cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("t4_sclk", {31'd0, sclk}, 32'd0);
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_rx", {16'd0, rx_data}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h0001);
    wait_frames(4, "t4_timeout");

    // start held high: two back-to-back frames.
    @(posedge clk); #1;
    tx_data = 16'h1234;
    start   = 1'b1;
    exp_q.push_back('{tx: 16'h1234, rx: (RX_EN ? 16'h1234 : 16'h0000)});
    exp_q.push_back('{tx: 16'h1234, rx: (RX_EN ? 16'h1234 : 16'h0000)});
    wait_frames(5, "t5_first");
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_frames(6, "t5_second");
    check_eq("t5_gap", last_gap, 2);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t5_no_third", frames_done, 6);

    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("sclk_when_cs_high", sclk_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
